// File: rtl/wb_cfg_arbiter.sv
// Two-requester round-robin arbiter in front of a single Wishbone classic slave.
// Optional bus timeout is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_cfg_arbiter #(
   parameter int unsigned TMO_CYCLES = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [1:0]  req_we,
   input  logic [23:0] req_adr,
   input  logic [63:0] req_dat,
   input  logic [7:0]  req_sel,
   output logic [1:0]  rsp_valid,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        rsp_tmo,
   output logic [9:0]  wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   if (TMO_CYCLES < 1 || TMO_CYCLES > 255) begin : g_bad_tmo
      $error("wb_cfg_arbiter: TMO_CYCLES must be in 1..255");
   end

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        gnt_id_q, gnt_id_d;
   logic [9:0]  adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;
   logic        we_q, we_d;
   logic        cyc_q, cyc_d;
   logic [1:0]  rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_dat_q, rsp_dat_d;
   logic        rsp_err_q, rsp_err_d;
   logic        gnt_any;
   logic        gnt_idx;
   logic        tmo_hit;

`ifdef WB_ARB_TIMEOUT_EN
   logic [7:0] tmo_cnt_q, tmo_cnt_d;
   logic       rsp_tmo_q, rsp_tmo_d;

   // Counter reads 1 on the first BUS cycle; a same-cycle ack/err beats the timeout.
   assign tmo_hit = (state_q == BUS) && (tmo_cnt_q == 8'(TMO_CYCLES));

   always_comb begin
      tmo_cnt_d = (state_q == BUS) ? tmo_cnt_q + 8'd1 : 8'd1;
      rsp_tmo_d = rsp_tmo_q;
      if (state_q == BUS && (wb_ack_i || wb_err_i || tmo_hit)) begin
         rsp_tmo_d = tmo_hit && !wb_ack_i && !wb_err_i;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         tmo_cnt_q <= 8'd1;
         rsp_tmo_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         rsp_tmo_q <= rsp_tmo_d;
      end
   end

   assign rsp_tmo = rsp_tmo_q;
`else
   assign tmo_hit = 1'b0;
   assign rsp_tmo = 1'b0;
`endif

   // With both pending, the requester not granted last wins.
   always_comb begin
      gnt_any = |req_valid;
      if (&req_valid) gnt_idx = ~last_q;
      else            gnt_idx = req_valid[1];
   end

   assign req_ready = (state_q == IDLE && gnt_any && !wb_rst_i) ?
                      (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gnt_id_d    = gnt_id_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      we_d        = we_q;
      cyc_d       = cyc_q;
      rsp_valid_d = 2'b00;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               state_d  = BUS;
               last_d   = gnt_idx;
               gnt_id_d = gnt_idx;
               adr_d    = gnt_idx ? req_adr[23:14] : req_adr[11:2];
               dat_d    = gnt_idx ? req_dat[63:32] : req_dat[31:0];
               sel_d    = gnt_idx ? req_sel[7:4]   : req_sel[3:0];
               we_d     = gnt_idx ? req_we[1]      : req_we[0];
               cyc_d    = 1'b1;
            end
         end
         BUS: begin
            if (wb_ack_i || wb_err_i || tmo_hit) begin
               state_d     = RESP;
               cyc_d       = 1'b0;
               we_d        = 1'b0;
               rsp_valid_d = gnt_id_q ? 2'b10 : 2'b01;
               rsp_err_d   = wb_err_i || (tmo_hit && !wb_ack_i);
               if (wb_ack_i && !wb_err_i) rsp_dat_d = wb_dat_i;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         gnt_id_q    <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         we_q        <= 1'b0;
         cyc_q       <= 1'b0;
         rsp_valid_q <= 2'b00;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gnt_id_q    <= gnt_id_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         we_q        <= we_d;
         cyc_q       <= cyc_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign wb_adr_o  = adr_q;
   assign wb_dat_o  = dat_q;
   assign wb_sel_o  = sel_q;
   assign wb_we_o   = we_q;
   assign wb_cyc_o  = cyc_q;
   assign wb_stb_o  = cyc_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_dat   = rsp_dat_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_cfg_arbiter.sv
// Directed bench for wb_cfg_arbiter; timeout steps follow WB_ARB_TIMEOUT_EN.
module tb_wb_cfg_arbiter;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_we;
   logic [23:0] req_adr;
   logic [63:0] req_dat;
   logic [7:0]  req_sel;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        rsp_tmo;
   logic [9:0]  wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;

   int n_checks = 0;
   int n_fail   = 0;

   wb_cfg_arbiter #(.TMO_CYCLES(4)) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we   (req_we),
      .req_adr  (req_adr),
      .req_dat  (req_dat),
      .req_sel  (req_sel),
      .rsp_valid(rsp_valid),
      .rsp_dat  (rsp_dat),
      .rsp_err  (rsp_err),
      .rsp_tmo  (rsp_tmo),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_sel_o (wb_sel_o),
      .wb_we_o  (wb_we_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack_i (wb_ack_i),
      .wb_err_i (wb_err_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      wb_rst_i  = 1'b1;
      req_valid = 2'b01;
      req_we    = 2'b00;
      req_adr   = '0;
      req_dat   = '0;
      req_sel   = '0;
      wb_dat_i  = '0;
      wb_ack_i  = 1'b0;
      wb_err_i  = 1'b0;
      #3;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_cyc", 32'(wb_cyc_o), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_adr", 32'(wb_adr_o), 32'h0);
      chk("rst_rsp_dat", rsp_dat, 32'h0);
      tick();
      tick();
      wb_rst_i  = 1'b0;
      req_valid = 2'b00;
      tick();

      // Single write from requester 0, ack on the 2nd BUS cycle
      req_valid     = 2'b01;
      req_we        = 2'b01;
      req_adr[11:0] = 12'h048;
      req_dat[31:0] = 32'hDEADBEEF;
      req_sel[3:0]  = 4'hF;
      #1;
      chk("wr_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      #1;
      chk("wr_cyc_bus1", 32'(wb_cyc_o), 32'h1);
      chk("wr_stb_bus1", 32'(wb_stb_o), 32'h1);
      chk("wr_we", 32'(wb_we_o), 32'h1);
      chk("wr_adr", 32'(wb_adr_o), 32'h012);
      chk("wr_dat", wb_dat_o, 32'hDEADBEEF);
      chk("wr_sel", 32'(wb_sel_o), 32'hF);
      chk("wr_ready_bus", 32'(req_ready), 32'h0);
      tick();
      wb_ack_i = 1'b1;
      #1;
      chk("wr_cyc_bus2", 32'(wb_cyc_o), 32'h1);
      chk("wr_rsp_early", 32'(rsp_valid), 32'h0);
      tick();
      wb_ack_i = 1'b0;
      chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("wr_rsp_err", 32'(rsp_err), 32'h0);
      chk("wr_rsp_tmo", 32'(rsp_tmo), 32'h0);
      chk("wr_cyc_resp", 32'(wb_cyc_o), 32'h0);
      chk("wr_we_resp", 32'(wb_we_o), 32'h0);
      tick();
      chk("wr_rsp_pulse", 32'(rsp_valid), 32'h0);

      // Stray ack while idle must not produce a response
      wb_ack_i = 1'b1;
      tick();
      wb_ack_i = 1'b0;
      chk("idle_ack_ignored", 32'(rsp_valid), 32'h0);
      chk("idle_cyc", 32'(wb_cyc_o), 32'h0);

      // Read from requester 1, ack on the first BUS cycle
      req_valid      = 2'b10;
      req_we         = 2'b00;
      req_adr[23:12] = 12'h400;
      #1;
      chk("rd_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = 2'b00;
      wb_ack_i  = 1'b1;
      wb_dat_i  = 32'h12345678;
      chk("rd_adr", 32'(wb_adr_o), 32'h100);
      chk("rd_we", 32'(wb_we_o), 32'h0);
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      chk("rd_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("rd_rsp_dat", rsp_dat, 32'h12345678);
      chk("rd_rsp_err", 32'(rsp_err), 32'h0);
      tick();

      // Round robin from reset with both requesters always pending
      wb_rst_i = 1'b1;
      tick();
      wb_rst_i       = 1'b0;
      req_adr[11:0]  = 12'h010;
      req_adr[23:12] = 12'h020;
      req_valid      = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
         chk("rr_cyc_idle", 32'(wb_cyc_o), 32'h0);
         tick();
         chk("rr_adr", 32'(wb_adr_o), (k % 2 == 0) ? 32'h004 : 32'h008);
         chk("rr_cyc_bus", 32'(wb_cyc_o), 32'h1);
         wb_ack_i = 1'b1;
         wb_dat_i = 32'hC0DE0000 + 32'(k);
         tick();
         wb_ack_i = 1'b0;
         chk("rr_rsp_valid", 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
         chk("rr_rsp_dat", rsp_dat, 32'hC0DE0000 + 32'(k));
         chk("rr_cyc_resp", 32'(wb_cyc_o), 32'h0);
         chk("rr_no_grant_resp", 32'(req_ready), 32'h0);
         tick();
      end
      req_valid = 2'b00;

      // Simultaneous ack and err: err wins
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      wb_ack_i  = 1'b1;
      wb_err_i  = 1'b1;
      tick();
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      chk("err_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("err_rsp_err", 32'(rsp_err), 32'h1);
      chk("err_rsp_tmo", 32'(rsp_tmo), 32'h0);
      tick();

      // Requester 1 with no slave response
      req_valid = 2'b10;
      tick();
      req_valid = 2'b00;
`ifdef WB_ARB_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         chk("tmo_cyc_high", 32'(wb_cyc_o), 32'h1);
         tick();
      end
      chk("tmo_cyc_low", 32'(wb_cyc_o), 32'h0);
      chk("tmo_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("tmo_rsp_err", 32'(rsp_err), 32'h1);
      chk("tmo_rsp_tmo", 32'(rsp_tmo), 32'h1);
      tick();
`else
      for (int i = 0; i < 10; i++) begin
         chk("wait_cyc_high", 32'(wb_cyc_o), 32'h1);
         chk("wait_no_rsp", 32'(rsp_valid), 32'h0);
         tick();
      end
      wb_ack_i = 1'b1;
      tick();
      wb_ack_i = 1'b0;
      chk("wait_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("wait_rsp_tmo", 32'(rsp_tmo), 32'h0);
      tick();
`endif

      // Reset during the 3rd BUS cycle of a requester-0 access
      req_valid = 2'b01;
      #1;
      chk("rst_mid_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      tick();
      tick();
      chk("rst_mid_cyc_bus3", 32'(wb_cyc_o), 32'h1);
      #2;
      wb_rst_i = 1'b1;
      #1;
      chk("rst_mid_cyc", 32'(wb_cyc_o), 32'h0);
      chk("rst_mid_stb", 32'(wb_stb_o), 32'h0);
      chk("rst_mid_adr", 32'(wb_adr_o), 32'h0);
      chk("rst_mid_rsp", 32'(rsp_valid), 32'h0);
      tick();
      wb_rst_i = 1'b0;
      chk("rst_mid_rsp_after", 32'(rsp_valid), 32'h0);
      tick();
      chk("rst_mid_rsp_after2", 32'(rsp_valid), 32'h0);
      chk("rst_mid_cyc_after", 32'(wb_cyc_o), 32'h0);
      req_valid = 2'b11;
      #1;
      chk("rst_mid_next_grant", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      wb_ack_i  = 1'b1;
      tick();
      wb_ack_i = 1'b0;
      chk("rst_mid_next_rsp", 32'(rsp_valid), 32'h1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
